phasegen_ext: RTL and testbench

//  Parametrised instruction-phase generator: one-hot phase vector of NPHASE phases,

---
 rtl/phasegen_ext.sv | 122 ++++++++++++
 tb/tb_phasegen_ext.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/phasegen_ext.sv
// phasegen_ext
// Instruction-phase generator. Produces a one-hot phase vector of NPHASE
// phases and sequences it from console commands: free run, single
// instruction and single phase. Other features:
//   - memory-stall hold
//   - graceful stop at an instruction boundary
//   - halt-on-instruction from the decoder
//   - retired-instruction counter
//   - end-of-instruction pulse
//
// Ports:
//   clock       rising-edge clock, single domain
//   reset       synchronous active-high reset
//   run         1-cycle pulse: start from STOP, or request stop while RUN
//   step_phase  1-cycle pulse: advance exactly one phase (STOP only)
//   step_inst   1-cycle pulse: finish the current instruction (STOP only)
//   stall       level: hold the current phase this cycle
//   halt        level: stop once the current instruction completes (RUN)
//   cstate      one-hot phase vector; bit 0 = first phase, bit NPHASE-1 = last
//   running     high whenever the sequencer is not stopped
//   inst_end    1-cycle pulse the cycle after the last phase completed
//   inst_count  retired-instruction count, wraps modulo 2^CNT_W

module phasegen_ext #(
    parameter int NPHASE = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step_phase,
    input  logic              step_inst,
    input  logic              stall,
    input  logic              halt,
    output logic [NPHASE-1:0] cstate,
    output logic              running,
    output logic              inst_end,
    output logic [CNT_W-1:0]  inst_count
);

    typedef enum logic [2:0] {
        STOP,
        RUN,
        STEP_INST,
        STEP_PHASE,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NPHASE-1:0] cstate_nxt;
    logic              adv;
    logic              stop_at_first;
    logic              step;
    logic              wrap;

    // Decide whether the phase vector moves this cycle and where the
    // sequencer goes next. A run request while RUN sits on phase 0 stops
    // before the next instruction starts. That stop does not advance, and
    // it is honoured even during a stall. A run request on any later phase
    // drains the current instruction instead. If that same cycle already
    // completes the instruction, there is nothing left to drain, so the
    // sequencer stops directly.
    always_comb begin
        state_nxt     = state;
        adv           = (state != STOP) && !stall;
        stop_at_first = (state == RUN) && run && cstate[0];
        step          = adv && !stop_at_first;
        wrap          = step && cstate[NPHASE-1];
        cstate_nxt    = step ? {cstate[NPHASE-2:0], cstate[NPHASE-1]} : cstate;

        case (state)
            STOP: begin
                if (run)
                    state_nxt = RUN;
                else if (step_inst)
                    state_nxt = STEP_INST;
                else if (step_phase)
                    state_nxt = STEP_PHASE;
            end
            RUN: begin
                if (run) begin
                    if (cstate[0] || wrap)
                        state_nxt = STOP;
                    else
                        state_nxt = DRAIN;
                end else if (wrap && halt) begin
                    state_nxt = STOP;
                end
            end
            DRAIN, STEP_INST: begin
                if (wrap)
                    state_nxt = STOP;
            end
            STEP_PHASE: begin
                if (adv)
                    state_nxt = STOP;
            end
            default: state_nxt = STOP;
        endcase
    end

    // State, phase vector, end pulse and retired count. A reset in the
    // middle of an instruction throws that instruction away uncounted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= STOP;
            cstate     <= {{(NPHASE-1){1'b0}}, 1'b1};
            inst_end   <= 1'b0;
            inst_count <= '0;
        end else begin
            state    <= state_nxt;
            cstate   <= cstate_nxt;
            inst_end <= wrap;
            if (wrap)
                inst_count <= inst_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign running = (state != STOP);

endmodule

// File: tb/tb_phasegen_ext.sv
// tb_phasegen_ext
// Scoreboard bench for phasegen_ext. Two instances are used: NPHASE=4 with
// CNT_W=16, and NPHASE=6 with CNT_W=3 for counter wrap. Each stimulus cycle
// pushes the hand-computed outputs expected after the next clock edge. An
// independent monitor pops and compares them on the falling edge.

module tb_phasegen_ext;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run4 = 1'b0;
    logic        run6 = 1'b0;
    logic        step_phase = 1'b0;
    logic        step_inst = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;

    logic [3:0]  cstate4;
    logic        running4;
    logic        inst_end4;
    logic [15:0] inst_count4;

    logic [5:0]  cstate6;
    logic        running6;
    logic        inst_end6;
    logic [2:0]  inst_count6;

    int cycle = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        bit          d6;
        logic [7:0]  cs;
        logic        rn;
        logic        ie;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    phasegen_ext #(.NPHASE(4), .CNT_W(16)) dut4 (
        .clock(clock), .reset(reset), .run(run4), .step_phase(step_phase),
        .step_inst(step_inst), .stall(stall), .halt(halt), .cstate(cstate4),
        .running(running4), .inst_end(inst_end4), .inst_count(inst_count4)
    );

    phasegen_ext #(.NPHASE(6), .CNT_W(3)) dut6 (
        .clock(clock), .reset(reset), .run(run6), .step_phase(step_phase),
        .step_inst(step_inst), .stall(stall), .halt(halt), .cstate(cstate6),
        .running(running6), .inst_end(inst_end6), .inst_count(inst_count6)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clock = ~clock;

    // Edge counter that lets the monitor match each queued expectation to
    // the clock edge it belongs to.
    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cycle);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the
    // next rising edge. Inputs change 1 time unit after the edge.
    task automatic applyStimulus(input bit r, input bit sp, input bit si,
                                 input bit st, input bit h, input bit rs,
                                 input bit d6, input logic [7:0] cs,
                                 input bit rn, input bit ie,
                                 input logic [15:0] cnt, input string name);
        exp_t e;
        reset      = rs;
        run4       = d6 ? 1'b0 : r;
        run6       = d6 ? r : 1'b0;
        step_phase = sp;
        step_inst  = si;
        stall      = st;
        halt       = h;
        e.cyc  = cycle + 1;
        e.d6   = d6;
        e.cs   = cs;
        e.rn   = rn;
        e.ie   = ie;
        e.cnt  = cnt;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Monitor: pop every expectation whose edge has arrived and compare it
    // with the instance it targets. An entry left behind is reported as a
    // failure.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cycle) begin
                checkOutput({e.name, "/stale"}, 16'(cycle), 16'(e.cyc));
            end else if (e.d6) begin
                checkOutput({e.name, "/cstate"}, {10'b0, cstate6}, {8'b0, e.cs});
                checkOutput({e.name, "/running"}, {15'b0, running6}, {15'b0, e.rn});
                checkOutput({e.name, "/inst_end"}, {15'b0, inst_end6}, {15'b0, e.ie});
                checkOutput({e.name, "/count"}, {13'b0, inst_count6}, e.cnt);
            end else begin
                checkOutput({e.name, "/cstate"}, {12'b0, cstate4}, {8'b0, e.cs});
                checkOutput({e.name, "/running"}, {15'b0, running4}, {15'b0, e.rn});
                checkOutput({e.name, "/inst_end"}, {15'b0, inst_end4}, {15'b0, e.ie});
                checkOutput({e.name, "/count"}, inst_count4, e.cnt);
            end
        end
    end

    // Stimulus: directed sequences with hand-computed outputs.
    // Argument order is r,sp,si,st,h,rs,d6 | cs,rn,ie,cnt,name.
    initial begin
        logic [7:0] run_seq [8];
        run_seq = '{8'h2, 8'h4, 8'h8, 8'h1, 8'h2, 8'h4, 8'h8, 8'h1};

        // Reset state.
        applyStimulus(0,0,0,0,0,1,0, 8'h1,0,0,0, "reset");

        // Test 1: start, then two full instructions.
        applyStimulus(1,0,0,0,0,0,0, 8'h1,1,0,0, "t1_start");
        for (int k = 0; k < 8; k++)
            applyStimulus(0,0,0,0,0,0,0, run_seq[k], 1, (k == 3 || k == 7),
                          (k < 3) ? 16'd0 : (k < 7) ? 16'd1 : 16'd2, "t1_run");
        applyStimulus(0,0,0,0,0,0,0, 8'h2,1,0,2, "t1_run");
        applyStimulus(0,0,0,0,0,0,0, 8'h4,1,0,2, "t1_run");

        // Test 2: stop request mid-instruction drains, then stop at phase 0.
        applyStimulus(1,0,0,0,0,0,0, 8'h8,1,0,2, "t2_drain");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,1,3, "t2_drain_end");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,0,3, "t2_stopped");
        applyStimulus(1,0,0,0,0,0,0, 8'h1,1,0,3, "t2_restart");
        applyStimulus(1,0,0,0,0,0,0, 8'h1,0,0,3, "t2_stop_now");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,0,3, "t2_hold");

        // Test 3: step one phase, then step_inst with a 3-cycle stall.
        applyStimulus(0,1,0,0,0,0,0, 8'h1,1,0,3, "t3_sp");
        applyStimulus(0,0,0,0,0,0,0, 8'h2,0,0,3, "t3_sp_done");
        applyStimulus(0,0,1,0,0,0,0, 8'h2,1,0,3, "t3_si");
        applyStimulus(0,0,0,0,0,0,0, 8'h4,1,0,3, "t3_adv");
        for (int k = 0; k < 3; k++)
            applyStimulus(0,0,0,1,0,0,0, 8'h4,1,0,3, "t3_stall");
        applyStimulus(0,0,0,0,0,0,0, 8'h8,1,0,3, "t3_adv");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,1,4, "t3_end");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,0,4, "t3_after");

        // Test 4: five single-phase steps from reset.
        applyStimulus(0,0,0,0,0,1,0, 8'h1,0,0,0, "t4_reset");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0,1,0,0,0,0,0, (k == 0 || k == 4) ? 8'h1 : run_seq[k-1],
                          1, 0, (k == 4) ? 16'd1 : 16'd0, "t4_cmd");
            applyStimulus(0,0,0,0,0,0,0, run_seq[k], 0, (k == 3),
                          (k >= 3) ? 16'd1 : 16'd0, "t4_step");
        end

        // A stalled single-phase step waits the stall out.
        applyStimulus(0,1,0,0,0,0,0, 8'h2,1,0,1, "t4_sp_cmd");
        applyStimulus(0,0,0,1,0,0,0, 8'h2,1,0,1, "t4_sp_stall");
        applyStimulus(0,0,0,0,0,0,0, 8'h4,0,0,1, "t4_sp_done");

        // Test 5a: halt at the last phase stops at the boundary.
        applyStimulus(1,0,0,0,0,0,0, 8'h4,1,0,1, "t5_start");
        applyStimulus(0,0,0,0,0,0,0, 8'h8,1,0,1, "t5_adv");
        applyStimulus(0,0,0,0,1,0,0, 8'h1,0,1,2, "t5_halt");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,0,2, "t5_stopped");

        // Commands ignored while running or draining.
        applyStimulus(1,0,0,0,0,0,0, 8'h1,1,0,2, "ign_start");
        applyStimulus(0,0,0,0,0,0,0, 8'h2,1,0,2, "ign_adv");
        applyStimulus(0,0,1,0,0,0,0, 8'h4,1,0,2, "ign_si_in_run");
        applyStimulus(1,0,0,0,0,0,0, 8'h8,1,0,2, "ign_to_drain");
        applyStimulus(1,0,0,0,0,0,0, 8'h1,0,1,3, "ign_run_in_drain");

        // Test 6: reset mid-instruction discards everything.
        applyStimulus(1,0,0,0,0,0,0, 8'h1,1,0,3, "t6_start");
        applyStimulus(0,0,0,0,0,0,0, 8'h2,1,0,3, "t6_adv");
        applyStimulus(0,0,0,0,0,0,0, 8'h4,1,0,3, "t6_adv");
        applyStimulus(0,0,0,0,0,1,0, 8'h1,0,0,0, "t6_reset");
        applyStimulus(0,0,0,0,0,0,0, 8'h1,0,0,0, "t6_idle");

        // Test 5b: NPHASE=6, CNT_W=3, 48 free cycles wraps the count to 0.
        applyStimulus(0,0,0,0,0,1,1, 8'h1,0,0,0, "t5b_reset");
        applyStimulus(1,0,0,0,0,0,1, 8'h1,1,0,0, "t5b_start");
        for (int k = 1; k <= 48; k++)
            applyStimulus(0,0,0,0,0,0,1, 8'(1 << (k % 6)), 1, (k % 6 == 0),
                          16'((k / 6) % 8), "t5b_run");

        @(negedge clock);
        #1;
        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
